// File: rtl/raster_scan_ctrl_if.sv
// Bus bundle for raster_scan_ctrl: triangle intake, inside-test link, fragment output and status.
// The controller uses the slave modport; the setup FIFO, inside-test unit and shader side form the master.
interface raster_scan_ctrl_if #(
  parameter int CW = 7
);
  logic               tri_valid;
  logic               tri_ready;
  logic signed [15:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic signed [15:0] ev_v0x, ev_v0y, ev_v1x, ev_v1y, ev_v2x, ev_v2y;
  logic signed [15:0] ev_px, ev_py;
  logic               ev_inside;
  logic               frag_valid;
  logic               frag_ready;
  logic [CW-1:0]      frag_x, frag_y;
  logic               busy;
  logic               tri_done;
  logic [15:0]        frag_count;

  modport slave (
    input  tri_valid, v0x, v0y, v1x, v1y, v2x, v2y, ev_inside, frag_ready,
    output tri_ready, ev_v0x, ev_v0y, ev_v1x, ev_v1y, ev_v2x, ev_v2y,
           ev_px, ev_py, frag_valid, frag_x, frag_y, busy, tri_done, frag_count
  );

  modport master (
    output tri_valid, v0x, v0y, v1x, v1y, v2x, v2y, ev_inside, frag_ready,
    input  tri_ready, ev_v0x, ev_v0y, ev_v1x, ev_v1y, ev_v2x, ev_v2y,
           ev_px, ev_py, frag_valid, frag_x, frag_y, busy, tri_done, frag_count
  );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Rasterizer front-end: latches one triangle, computes its screen-clipped bounding box and
// walks it row-major one sample per cycle, emitting covered pixels as fragments with backpressure.
module raster_scan_ctrl #(
  parameter int FRAC_BITS = 8,
  parameter int SCREEN_W  = 128,
  parameter int SCREEN_H  = 96,
  parameter int CW        = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  raster_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

  localparam logic signed [15:0] X_LIM = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H - 1);

  state_t             r_state, w_next;
  logic signed [15:0] r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y;
  logic [CW-1:0]      r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
  logic [15:0]        r_frag_count;

  logic               w_latch, w_load, w_step_x, w_step_y, w_accept;
  logic               w_tri_ready, w_frag_valid, w_tri_done, w_empty;
  logic signed [15:0] w_xlo, w_xhi, w_ylo, w_yhi;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [CW-1:0] clampc(input logic signed [15:0] v, input logic signed [15:0] lim);
    logic [CW-1:0] res;
    if (v < 16'sd0)     res = '0;
    else if (v > lim)   res = lim[CW-1:0];
    else                res = v[CW-1:0];
    return res;
  endfunction

  // Arithmetic shift floors toward -inf, so negative fractional vertices land on the correct pixel
  assign w_xlo = min3(r_v0x, r_v1x, r_v2x) >>> FRAC_BITS;
  assign w_xhi = max3(r_v0x, r_v1x, r_v2x) >>> FRAC_BITS;
  assign w_ylo = min3(r_v0y, r_v1y, r_v2y) >>> FRAC_BITS;
  assign w_yhi = max3(r_v0y, r_v1y, r_v2y) >>> FRAC_BITS;

  assign w_empty = (w_xhi < 16'sd0) || (w_xlo > X_LIM) || (w_yhi < 16'sd0) || (w_ylo > Y_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_step_x     = 1'b0;
    w_step_y     = 1'b0;
    w_accept     = 1'b0;
    w_tri_ready  = 1'b0;
    w_frag_valid = 1'b0;
    w_tri_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tri_ready = 1'b1;
        if (bus.tri_valid) begin
          w_latch = 1'b1;
          w_next  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_empty) begin
          w_next = S_DONE;
        end else begin
          w_load = 1'b1;
          w_next = S_SCAN;
        end
      end
      S_SCAN: begin
        w_frag_valid = bus.ev_inside;
        w_accept     = bus.ev_inside & bus.frag_ready;
        // A covered sample only moves on once the fragment is taken; uncovered samples never stall
        if (!bus.ev_inside || bus.frag_ready) begin
          if (r_x < r_xmax)      w_step_x = 1'b1;
          else if (r_y < r_ymax) w_step_y = 1'b1;
          else                   w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_tri_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0x        <= '0;
      r_v0y        <= '0;
      r_v1x        <= '0;
      r_v1y        <= '0;
      r_v2x        <= '0;
      r_v2y        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_xmin       <= '0;
      r_xmax       <= '0;
      r_ymin       <= '0;
      r_ymax       <= '0;
      r_frag_count <= '0;
    end else begin
      if (w_latch) begin
        r_v0x        <= bus.v0x;
        r_v0y        <= bus.v0y;
        r_v1x        <= bus.v1x;
        r_v1y        <= bus.v1y;
        r_v2x        <= bus.v2x;
        r_v2y        <= bus.v2y;
        r_frag_count <= '0;
      end
      if (w_load) begin
        r_xmin <= clampc(w_xlo, X_LIM);
        r_xmax <= clampc(w_xhi, X_LIM);
        r_ymin <= clampc(w_ylo, Y_LIM);
        r_ymax <= clampc(w_yhi, Y_LIM);
        r_x    <= clampc(w_xlo, X_LIM);
        r_y    <= clampc(w_ylo, Y_LIM);
      end
      if (w_step_x) r_x <= r_x + 1'b1;
      if (w_step_y) begin
        r_x <= r_xmin;
        r_y <= r_y + 1'b1;
      end
      if (w_accept && (r_frag_count != 16'hFFFF)) r_frag_count <= r_frag_count + 16'd1;
    end
  end

  assign bus.tri_ready  = w_tri_ready;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.tri_done   = w_tri_done;
  assign bus.frag_valid = w_frag_valid;
  assign bus.frag_x     = r_x;
  assign bus.frag_y     = r_y;
  assign bus.frag_count = r_frag_count;
  assign bus.ev_v0x     = r_v0x;
  assign bus.ev_v0y     = r_v0y;
  assign bus.ev_v1x     = r_v1x;
  assign bus.ev_v1y     = r_v1y;
  assign bus.ev_v2x     = r_v2x;
  assign bus.ev_v2y     = r_v2y;
  assign bus.ev_px      = $signed({{(16-CW-FRAC_BITS){1'b0}}, r_x, {FRAC_BITS{1'b0}}});
  assign bus.ev_py      = $signed({{(16-CW-FRAC_BITS){1'b0}}, r_y, {FRAC_BITS{1'b0}}});

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench for raster_scan_ctrl: directed triangles push expected fragments into a queue,
// a monitor pops and compares each accepted fragment; an edge-function model plays the inside-test unit.
module tb_raster_scan_ctrl;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   expQ[$];
  bit   bpMode = 1'b0;
  logic fragReady;

  logic signed [15:0] tvx[3];
  logic signed [15:0] tvy[3];

  raster_scan_ctrl_if bus();

  raster_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.frag_ready = fragReady;

  // Downstream acceptor: always ready, or toggling every cycle in backpressure mode
  initial begin
    fragReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fragReady = bpMode ? ~fragReady : 1'b1;
    end
  end

  function automatic longint edgeFn(input longint ax, ay, bx, by, px, py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic insideModel(input longint ax, ay, bx, by, cx, cy, px, py);
    longint e0, e1, e2;
    e0 = edgeFn(ax, ay, bx, by, px, py);
    e1 = edgeFn(bx, by, cx, cy, px, py);
    e2 = edgeFn(cx, cy, ax, ay, px, py);
    return ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) || ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
  endfunction

  assign bus.ev_inside = insideModel(bus.ev_v0x, bus.ev_v0y, bus.ev_v1x, bus.ev_v1y,
                                     bus.ev_v2x, bus.ev_v2y, bus.ev_px, bus.ev_py);

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fragment monitor and stall-stability checker
  initial begin
    bit stalled;
    int sx, sy, spx, exp;
    stalled = 1'b0;
    sx = 0; sy = 0; spx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall_frag_x", bus.frag_x, sx);
          checkOutput("stall_frag_y", bus.frag_y, sy);
          checkOutput("stall_ev_px", bus.ev_px, spx);
        end
        if (bus.frag_valid === 1'b1 && bus.frag_ready === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_frag", bus.frag_x * 256 + bus.frag_y, -1);
          end else begin
            exp = expQ.pop_front();
            checkOutput("frag_xy", bus.frag_x * 256 + bus.frag_y, exp);
          end
        end
        stalled = (bus.frag_valid === 1'b1) && (bus.frag_ready === 1'b0);
        sx  = bus.frag_x;
        sy  = bus.frag_y;
        spx = bus.ev_px;
      end
    end
  end

  task automatic pushFrag(input int x, input int y);
    expQ.push_back(x * 256 + y);
  endtask

  task automatic driveTri(output int p);
    @(negedge clk);
    checkOutput("tri_ready_idle", bus.tri_ready, 1);
    bus.v0x = tvx[0]; bus.v0y = tvy[0];
    bus.v1x = tvx[1]; bus.v1y = tvy[1];
    bus.v2x = tvx[2]; bus.v2y = tvy[2];
    bus.tri_valid = 1'b1;
    @(negedge clk);
    p = cyc;
    bus.tri_valid = 1'b0;
    bus.v0x = 16'sh7F00; bus.v0y = 16'sh7F00;
    bus.v1x = 16'sh7F00; bus.v1y = 16'sh7F00;
    bus.v2x = 16'sh7F00; bus.v2y = 16'sh7F00;
    checkOutput("busy_setup", bus.busy, 1);
    checkOutput("tri_ready_busy", bus.tri_ready, 0);
    checkOutput("ev_v1y_latched", bus.ev_v1y, tvy[1]);
  endtask

  // testId: 0 basic, 1 backpressure, 2 clipping, 3 offscreen, 4 degenerate
  task automatic applyStimulus(input int testId);
    int n, expCount, p, waited;
    bit checkTiming;
    expCount = 0;
    checkTiming = 1'b1;
    n = 0;
    case (testId)
      0, 1: begin
        tvx = '{16'sd0, 16'sd0, 16'sd1024};
        tvy = '{16'sd0, 16'sd1024, 16'sd0};
        n = 25;
        for (int y = 0; y <= 4; y++)
          for (int x = 0; x <= 4; x++)
            if (x + y <= 4) begin pushFrag(x, y); expCount++; end
        checkTiming = (testId == 0);
      end
      2: begin
        tvx = '{-16'sd2560, -16'sd2560, 16'sd5120};
        tvy = '{-16'sd2560, 16'sd5120, -16'sd2560};
        n = 441;
        for (int y = 0; y <= 20; y++)
          for (int x = 0; x <= 20; x++)
            if (x + y <= 10) begin pushFrag(x, y); expCount++; end
      end
      3: begin
        tvx = '{-16'sd5120, -16'sd1280, -16'sd3072};
        tvy = '{16'sd0, 16'sd2560, 16'sd5120};
        n = 0;
      end
      default: begin
        tvx = '{16'sd0, 16'sd512, 16'sd1024};
        tvy = '{16'sd0, 16'sd512, 16'sd1024};
        n = 25;
        for (int k = 0; k <= 4; k++) begin pushFrag(k, k); expCount++; end
      end
    endcase
    bpMode = (testId == 1);
    driveTri(p);
    waited = 0;
    while (bus.tri_done !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("tri_done_seen", bus.tri_done, 1);
    if (checkTiming) checkOutput("tri_done_cycle", cyc - p, n + 1);
    checkOutput("frag_count", bus.frag_count, expCount);
    checkOutput("ev_v2x_held", bus.ev_v2x, tvx[2]);
    checkOutput("frags_outstanding", expQ.size(), 0);
    @(negedge clk);
    checkOutput("tri_ready_after", bus.tri_ready, 1);
    checkOutput("busy_after", bus.busy, 0);
    checkOutput("tri_done_pulse", bus.tri_done, 0);
    bpMode = 1'b0;
    expQ.delete();
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tri_ready"}, bus.tri_ready, 1);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_tri_done"}, bus.tri_done, 0);
    checkOutput({tag, "_frag_valid"}, bus.frag_valid, 0);
    checkOutput({tag, "_frag_count"}, bus.frag_count, 0);
    checkOutput({tag, "_ev_px"}, bus.ev_px, 0);
    checkOutput({tag, "_ev_v0x"}, bus.ev_v0x, 0);
  endtask

  initial begin
    int p, seen, waited;
    rst_n = 1'b0;
    bus.tri_valid = 1'b0;
    bus.v0x = '0; bus.v0y = '0; bus.v1x = '0;
    bus.v1y = '0; bus.v2x = '0; bus.v2y = '0;
    #1;
    checkResetState("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0);
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    applyStimulus(4);

    // Reset mid-scan of the basic triangle, right after the third fragment is taken
    tvx = '{16'sd0, 16'sd0, 16'sd1024};
    tvy = '{16'sd0, 16'sd1024, 16'sd0};
    pushFrag(0, 0); pushFrag(1, 0); pushFrag(2, 0);
    driveTri(p);
    seen = 0;
    waited = 0;
    while (seen < 3 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (bus.frag_valid === 1'b1 && bus.frag_ready === 1'b1) seen++;
    end
    checkOutput("third_frag_reached", seen, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    @(negedge clk);
    @(negedge clk);
    checkOutput("midreset_no_done", bus.tri_done, 0);
    checkOutput("midreset_frags_outstanding", expQ.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
